// File: rtl/vdc_vram_cpu_port_pkg.sv
// Shared constants, FSM state type and address-step decode for the VDC CPU/VRAM port.
package huc6270_pkg;

    localparam logic [4:0] REG_MAWR = 5'd0;
    localparam logic [4:0] REG_MARR = 5'd1;
    localparam logic [4:0] REG_VWR  = 5'd2;
    localparam logic [4:0] REG_CR   = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_RD_REQ,
        ST_RD_WAIT
    } state_e;

    // CR increment field: 1, 32, 64 or 128 words per access
    function automatic logic [15:0] inc_decode(input logic [1:0] sel);
        logic [15:0] step;
        case (sel)
            2'd0:    step = 16'd1;
            2'd1:    step = 16'd32;
            2'd2:    step = 16'd64;
            default: step = 16'd128;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/vdc_vram_cpu_port_if.sv
// CPU register bus, forwarded-register strobe and VRAM slot handshake of the VDC CPU port.
interface vdc_vram_cpu_port_if #(parameter int ADDR_W = 16);

    logic              cpu_cs;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [1:0]        cpu_a;
    logic [7:0]        cpu_d_in;
    logic [7:0]        cpu_d_out;
    logic              busy;

    logic              oreg_we;
    logic [4:0]        oreg_num;
    logic              oreg_hi;
    logic [7:0]        oreg_data;

    logic              vram_req;
    logic              vram_gnt;
    logic [ADDR_W-1:0] vram_ma;
    logic              vram_re;
    logic              vram_we;
    logic [15:0]       vram_md_out;
    logic [15:0]       vram_md_in;

    modport slave (
        input  cpu_cs, cpu_wr, cpu_rd, cpu_a, cpu_d_in, vram_gnt, vram_md_in,
        output cpu_d_out, busy, oreg_we, oreg_num, oreg_hi, oreg_data,
               vram_req, vram_ma, vram_re, vram_we, vram_md_out
    );

    modport master (
        output cpu_cs, cpu_wr, cpu_rd, cpu_a, cpu_d_in, vram_gnt, vram_md_in,
        input  cpu_d_out, busy, oreg_we, oreg_num, oreg_hi, oreg_data,
               vram_req, vram_ma, vram_re, vram_we, vram_md_out
    );

endinterface

// File: rtl/vdc_vram_cpu_port.sv
// HuC6270 CPU-side VRAM port: MAWR/MARR/VWR/VRR registers, auto-increment, read-ahead,
// and arbitrated word access to VRAM. Bytes for other registers are forwarded on oreg.
module vdc_vram_cpu_port
    import huc6270_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int VRAM_WORDS = 32768
) (
    input  logic                clock,
    input  logic                reset,
    vdc_vram_cpu_port_if.slave  bus
);

    localparam logic [ADDR_W:0] VRAM_LIM = VRAM_WORDS[ADDR_W:0];

    state_e            state_q, state_d;
    logic [4:0]        ar_q, ar_d;
    logic [ADDR_W-1:0] mawr_q, mawr_d;
    logic [ADDR_W-1:0] marr_q, marr_d;
    logic [15:0]       vwr_q, vwr_d;
    logic [15:0]       vrr_q, vrr_d;
    logic [1:0]        inc_sel_q, inc_sel_d;
    logic              oreg_we_q, oreg_we_d;
    logic              oreg_hi_q, oreg_hi_d;
    logic [7:0]        oreg_data_q, oreg_data_d;

    logic [ADDR_W-1:0] inc;
    logic              cpu_wr_s, cpu_rd_s, gnt_s, wr_in_range;

    assign inc         = ADDR_W'(inc_decode(inc_sel_q));
    assign cpu_wr_s    = bus.cpu_cs & bus.cpu_wr;
    assign cpu_rd_s    = bus.cpu_cs & bus.cpu_rd;
    assign gnt_s       = bus.vram_req & bus.vram_gnt;
    assign wr_in_range = ({1'b0, mawr_q} < VRAM_LIM);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ar_q        <= '0;
            mawr_q      <= '0;
            marr_q      <= '0;
            vwr_q       <= '0;
            vrr_q       <= '0;
            inc_sel_q   <= '0;
            oreg_we_q   <= 1'b0;
            oreg_hi_q   <= 1'b0;
            oreg_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ar_q        <= ar_d;
            mawr_q      <= mawr_d;
            marr_q      <= marr_d;
            vwr_q       <= vwr_d;
            vrr_q       <= vrr_d;
            inc_sel_q   <= inc_sel_d;
            oreg_we_q   <= oreg_we_d;
            oreg_hi_q   <= oreg_hi_d;
            oreg_data_q <= oreg_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ar_d        = ar_q;
        mawr_d      = mawr_q;
        marr_d      = marr_q;
        vwr_d       = vwr_q;
        vrr_d       = vrr_q;
        inc_sel_d   = inc_sel_q;
        oreg_we_d   = 1'b0;
        oreg_hi_d   = oreg_hi_q;
        oreg_data_d = oreg_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_wr_s) begin
                    case (bus.cpu_a)
                        2'd0: ar_d = bus.cpu_d_in[4:0];
                        2'd2: begin
                            case (ar_q)
                                REG_MAWR: mawr_d[7:0] = bus.cpu_d_in;
                                REG_MARR: marr_d[7:0] = bus.cpu_d_in;
                                REG_VWR:  vwr_d[7:0]  = bus.cpu_d_in;
                                default: begin
                                    oreg_we_d   = 1'b1;
                                    oreg_hi_d   = 1'b0;
                                    oreg_data_d = bus.cpu_d_in;
                                end
                            endcase
                        end
                        2'd3: begin
                            case (ar_q)
                                REG_MAWR: mawr_d[ADDR_W-1:8] = bus.cpu_d_in;
                                REG_MARR: begin
                                    marr_d[ADDR_W-1:8] = bus.cpu_d_in;
                                    state_d            = ST_RD_REQ;
                                end
                                REG_VWR: begin
                                    vwr_d[15:8] = bus.cpu_d_in;
                                    state_d     = ST_WR_REQ;
                                end
                                default: begin
                                    // CR's increment field is mirrored here; the byte still goes to the register file
                                    if (ar_q == REG_CR)
                                        inc_sel_d = bus.cpu_d_in[4:3];
                                    oreg_we_d   = 1'b1;
                                    oreg_hi_d   = 1'b1;
                                    oreg_data_d = bus.cpu_d_in;
                                end
                            endcase
                        end
                        default: ;
                    endcase
                end else if (cpu_rd_s && bus.cpu_a == 2'd3) begin
                    // Read-ahead: consuming VRR high byte fetches the next word
                    marr_d  = marr_q + inc;
                    state_d = ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (gnt_s) begin
                    mawr_d  = mawr_q + inc;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (gnt_s)
                    state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                vrr_d   = bus.vram_md_in;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_d_out = 8'h00;
        case (bus.cpu_a)
            2'd2:    bus.cpu_d_out = vrr_q[7:0];
            2'd3:    bus.cpu_d_out = vrr_q[15:8];
            default: bus.cpu_d_out = 8'h00;
        endcase
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.vram_req    = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
    assign bus.vram_ma     = (state_q == ST_WR_REQ) ? mawr_q :
                             (state_q == ST_RD_REQ) ? marr_q : '0;
    assign bus.vram_re     = gnt_s & (state_q == ST_RD_REQ);
    assign bus.vram_we     = gnt_s & (state_q == ST_WR_REQ) & wr_in_range;
    assign bus.vram_md_out = (state_q == ST_WR_REQ) ? vwr_q : 16'h0000;

    assign bus.oreg_we     = oreg_we_q;
    assign bus.oreg_num    = ar_q;
    assign bus.oreg_hi     = oreg_hi_q;
    assign bus.oreg_data   = oreg_data_q;

endmodule

// File: doc/vdc_vram_cpu_port.md
Name: vdc_vram_cpu_port

Overview:
- CPU-side VRAM access stage of the HuC6270 VDC. Sits directly upstream of the VRAM model and drives its address, read-enable, write-enable and write-data.
- Owns the MAWR (reg 0), MARR (reg 1) and VWR/VRR (reg 2) registers, plus the CR address-increment field.
- Turns byte-wide CPU register accesses into arbitrated 16-bit VRAM word reads and writes, with auto-increment and read-ahead.
- Forwards writes to all other VDC registers to the register file.

Parameters:
- ADDR_W, 16, VRAM word-address width.
- VRAM_WORDS, 32768, physical VRAM size; writes at or above this address are suppressed.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_cs  in  1  chip select
- cpu_wr  in  1  write strobe, one cycle, qualified by cpu_cs
- cpu_rd  in  1  read strobe, one cycle, qualified by cpu_cs
- cpu_a  in  2  0=address register (AR), 2=data low byte, 3=data high byte; 1 unused
- cpu_d_in  in  8  CPU write data
- cpu_d_out  out  8  CPU read data, combinational from registers
- busy  out  1  VRAM transaction pending; CPU must stall
- oreg_we  out  1  one-cycle strobe: byte write to a register not owned here
- oreg_num  out  5  current AR value
- oreg_hi  out  1  1=high byte
- oreg_data  out  8  byte written
- vram_req  out  1  request VRAM slot
- vram_gnt  in  1  slot granted this cycle
- vram_ma  out  16  VRAM word address
- vram_re  out  1  read enable
- vram_we  out  1  write enable
- vram_md_out  out  16  write data to VRAM
- vram_md_in  in  16  VRAM read data, valid one cycle after vram_re

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values:
  - AR, MAWR, MARR, VWR, VRR and inc_sel are all 0.
  - State is IDLE.
  - All outputs are 0.
- Reset mid-transaction: the transaction is abandoned. vram_req and busy are low on the cycle after reset is sampled.
- CPU writes, decoded only when state==IDLE:
  - a=0: AR <= d[4:0].
  - a=2, AR=0/1/2: low byte of MAWR/MARR/VWR.
  - a=3, AR=0: MAWR[15:8].
  - a=3, AR=1: MARR[15:8], then start a READ at the new MARR.
  - a=3, AR=2: VWR[15:8], then start a WRITE of {d, VWR[7:0]} to MAWR.
  - a=3, AR=5: inc_sel <= d[4:3]; the byte is also forwarded on the oreg interface.
  - a=2/3 with any other AR: forwarded on oreg (oreg_we for 1 cycle); no local effect.
- CPU reads:
  - a=2 returns VRR[7:0].
  - a=3 returns VRR[15:8]; on that same cycle MARR <= MARR+inc and a READ starts at the new MARR (read-ahead).
  - a=0/1 return 8'h00; status is muxed at top level.
- Increment decode: inc_sel 0->1, 1->32, 2->64, 3->128. Arithmetic is 16-bit and wraps (0xFFFF+1 -> 0x0000).
- Accesses while busy=1 are ignored, with no register side effects. cpu_d_out still returns the current VRR bytes.
- Handshake:
  - vram_req is held high with a stable vram_ma until the cycle vram_gnt=1.
  - vram_re = req & gnt & read; vram_we = req & gnt & write & (MAWR < VRAM_WORDS).
  - vram_md_out = VWR while writing.
- FSM states IDLE, WR_REQ, RD_REQ, RD_WAIT:
  - IDLE -> WR_REQ or RD_REQ on the triggering access.
  - WR_REQ: on gnt, MAWR <= MAWR+inc, -> IDLE.
  - RD_REQ: on gnt -> RD_WAIT.
  - RD_WAIT: VRR <= vram_md_in, -> IDLE.
  - busy = (state != IDLE).
- Latency with immediate grant, trigger sampled at cycle T:
  - Write: we at T+1, busy low at T+2.
  - Read: re at T+1, VRR updated and busy low at T+3.
- Suppressed write (MAWR >= VRAM_WORDS): still takes the slot and still increments MAWR.
- MARR is not incremented by a MARR-high write; only by a VRR-high read.

Decomposition:
- Package huc6270_pkg holds:
  - register-number constants (REG_MAWR=0, REG_MARR=1, REG_VWR=2, REG_CR=5);
  - the state enum;
  - the inc_decode function (2-bit -> 16-bit step).
- No sub-module; single-level FSM with datapath.

Test Plan:
- Write AR=0, lo 0x00, hi 0x10; AR=2, lo 0x34, hi 0x12 (gnt tied 1) -> one cycle with vram_we=1, ma=0x1000, md=0x1234; busy low 2 cycles after the hi write; MAWR=0x1001.
- Write CR hi d=0x08 (inc_sel=1); VWR hi written three times -> writes at 0x1000, 0x1020, 0x1040; oreg_we pulses once with num=5, hi=1, data=0x08.
- Preload VRAM[0x2000]=0xBEEF, [0x2001]=0xCAFE; MARR hi=0x20 (lo 0) -> re at ma=0x2000; VRR=0xBEEF at T+3; read a=3 returns 0xBE and a new read at 0x2001; next a=2/a=3 reads return 0xFE/0xCA.
- Hold vram_gnt=0 for 5 cycles after a VWR hi write -> vram_req and ma held stable; busy=1; a CPU write to MAWR during the stall is ignored; we fires on the first gnt.
- MAWR=0xFFFF, VWR write -> vram_we stays 0 (suppressed), req/gnt still completes, MAWR wraps to 0x0000.
- Assert reset one cycle after a MARR hi write -> req, busy and VRR are 0 on the next cycle; no re is issued afterwards.
